// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet MAC transmit-side blocks.
// Holds the scheduler state encoding, the buffer geometry and a saturating counter helper.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PAD  = 3'd2,
        SEND = 3'd3,
        GAP  = 3'd4,
        DROP = 3'd5
    } Ttx_sched_state;

    localparam int ETH_BUF_DEPTH   = 1024;
    localparam int ETH_MIN_PAYLOAD = 60;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index for the first request at or after the pointer.
// The pointer moves past the granted index when advance is strobed.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_idx,
    output logic               any
);

    logic [GW-1:0] ptr_r;
    int            pos_s;
    logic          hit_s;

    // Scan requests starting at the pointer, wrapping once around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos_s     = 0;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_s     = (int'(ptr_r) + i >= NUM_REQ) ? int'(ptr_r) + i - NUM_REQ : int'(ptr_r) + i;
            hit_s     = !any && req[GW'(pos_s)];
            grant_idx = hit_s ? GW'(pos_s) : grant_idx;
            any       = any | hit_s;
        end
        grant[grant_idx] = any;
    end

    // Pointer register: highest priority goes to the source after the one just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + GW'(1);
        end
    end

endmodule

// File: rtl/ethernet_tx_scheduler.sv
// Arbitrates byte-stream frame sources into the ethernet_tx frame buffer, pads short frames,
// hands them to the transmitter, enforces the inter-frame gap and drops oversize frames.
module ethernet_tx_scheduler
    import eth_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  MAX_LEN    = ETH_BUF_DEPTH,
    parameter int  MIN_LEN    = ETH_MIN_PAYLOAD,
    parameter int  IFG_CYCLES = 192,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           buf_data,
    output logic [9:0]           buf_addr,
    output logic                 buf_we,
    output logic [9:0]           packet_size,
    output logic                 tx_enable,
    input  logic                 tx_finished,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [15:0]          drop_count
);

    Ttx_sched_state       state_r, next_state_s;
    logic [10:0]          cnt_r;
    logic [15:0]          gap_r;
    logic [GW-1:0]        grant_id_r;
    logic [NUM_REQ-1:0]   req_ready_r, ready_next_s;
    logic [7:0]           buf_data_r;
    logic [9:0]           buf_addr_r, packet_size_r;
    logic                 buf_we_r, tx_enable_r, busy_r;
    logic [15:0]          drop_count_r;

    logic [NUM_REQ-1:0]   arb_grant_s;
    logic [GW-1:0]        arb_idx_s;
    logic                 arb_any_s, advance_s;
    logic                 cur_valid_s, cur_last_s, xfer_s;
    logic [7:0]           cur_data_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (tx_clk),
        .rst       (tx_rst),
        .req       (req_valid),
        .advance   (advance_s),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any       (arb_any_s)
    );

    // Select the granted source's byte lane and decide the next state.
    always_comb begin
        next_state_s = state_r;
        advance_s    = 1'b0;
        cur_valid_s  = req_valid[grant_id_r];
        cur_last_s   = req_last[grant_id_r];
        cur_data_s   = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_data_s = (grant_id_r == GW'(i)) ? req_data[8*i +: 8] : cur_data_s;
        end
        xfer_s       = cur_valid_s & req_ready_r[grant_id_r];
        ready_next_s = '0;
        if (state_r == IDLE) begin
            ready_next_s = arb_grant_s;
        end else begin
            ready_next_s[grant_id_r] = 1'b1;
        end

        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    next_state_s = LOAD;
                    advance_s    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                // Every completed frame passes through PAD so the final registered write
                // lands before tx_enable rises.
                if (xfer_s && cur_last_s) begin
                    next_state_s = PAD;
                end else if (xfer_s && (cnt_r == 11'(MAX_LEN - 1))) begin
                    next_state_s = DROP;
                end else begin
                    next_state_s = LOAD;
                end
            end
            PAD: begin
                if (cnt_r >= 11'(MIN_LEN)) begin
                    next_state_s = SEND;
                end else begin
                    next_state_s = PAD;
                end
            end
            SEND: begin
                if (tx_finished) begin
                    next_state_s = GAP;
                end else begin
                    next_state_s = SEND;
                end
            end
            GAP: begin
                if (gap_r == 16'(IFG_CYCLES - 1)) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            DROP: begin
                if (xfer_s && cur_last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DROP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, counters and registered outputs; handshake outputs decode the next state.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            gap_r         <= '0;
            grant_id_r    <= '0;
            req_ready_r   <= '0;
            buf_we_r      <= 1'b0;
            buf_addr_r    <= '0;
            buf_data_r    <= '0;
            packet_size_r <= '0;
            tx_enable_r   <= 1'b0;
            busy_r        <= 1'b0;
            drop_count_r  <= '0;
        end else begin
            state_r     <= next_state_s;
            tx_enable_r <= (next_state_s == SEND);
            busy_r      <= (next_state_s != IDLE);
            req_ready_r <= ((next_state_s == LOAD) || (next_state_s == DROP)) ? ready_next_s : '0;
            buf_we_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    gap_r <= '0;
                    if (arb_any_s) begin
                        grant_id_r <= arb_idx_s;
                    end
                end
                LOAD: begin
                    if (xfer_s) begin
                        buf_we_r   <= 1'b1;
                        buf_addr_r <= cnt_r[9:0];
                        buf_data_r <= cur_data_s;
                        cnt_r      <= cnt_r + 11'd1;
                    end
                end
                PAD: begin
                    if (cnt_r < 11'(MIN_LEN)) begin
                        buf_we_r   <= 1'b1;
                        buf_addr_r <= cnt_r[9:0];
                        buf_data_r <= 8'h00;
                        cnt_r      <= cnt_r + 11'd1;
                    end else begin
                        packet_size_r <= 10'(cnt_r - 11'd1);
                    end
                end
                SEND: gap_r <= '0;
                GAP:  gap_r <= gap_r + 16'd1;
                DROP: begin
                    if (xfer_s && cur_last_s) begin
                        drop_count_r <= sat_inc16(drop_count_r);
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign buf_data    = buf_data_r;
    assign buf_addr    = buf_addr_r;
    assign buf_we      = buf_we_r;
    assign packet_size = packet_size_r;
    assign tx_enable   = tx_enable_r;
    assign grant_id    = grant_id_r;
    assign busy        = busy_r;
    assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// Self-checking bench for ethernet_tx_scheduler: frame table, scoreboard of buffer writes,
// round-robin and reset sequences.
module tb_ethernet_tx_scheduler;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [1:0]  req_valid, req_last, req_ready;
    logic [15:0] req_data;
    logic [7:0]  buf_data;
    logic [9:0]  buf_addr, packet_size;
    logic        buf_we, tx_enable, tx_finished, busy;
    logic [0:0]  grant_id;
    logic [15:0] drop_count;

    logic        src_valid [2];
    logic [7:0]  src_data  [2];
    logic        src_last  [2];

    assign req_valid = {src_valid[1], src_valid[0]};
    assign req_last  = {src_last[1], src_last[0]};
    assign req_data  = {src_data[1], src_data[0]};

    always #5 tx_clk = ~tx_clk;

    ethernet_tx_scheduler dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .buf_data(buf_data), .buf_addr(buf_addr),
        .buf_we(buf_we), .packet_size(packet_size), .tx_enable(tx_enable),
        .tx_finished(tx_finished), .grant_id(grant_id), .busy(busy), .drop_count(drop_count)
    );

    typedef struct { logic [9:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int src; int len; int gapmax; int hold; int sent; int size; int drops; } row_t;

    wr_t  sb [$];
    row_t rows [10];
    int   errors = 0;
    int   checks = 0;
    int   rises = 0;
    logic prev_te = 1'b0;
    int   bytes_sent [2];
    bit   abort = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected buffer writes, watch ready one-hotness and write/transmit overlap.
    always @(negedge tx_clk) begin
        wr_t e;
        if (buf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", buf_addr, buf_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", buf_addr, e.addr);
                check("wr_data", buf_data, e.data);
            end
        end
        if (tx_enable) check("we_during_tx", buf_we, 0);
        if (req_ready != 2'b00) check("ready_onehot", req_ready, 2'b01 << grant_id);
        if (tx_enable && !prev_te) rises++;
        prev_te = tx_enable;
    end

    task automatic drive_frame(input int s, input int len, input int gapmax, input int base);
        int t;
        for (int b = 0; b < len && !abort; b++) begin
            if (gapmax > 0 && b > 0) begin
                src_valid[s] = 1'b0;
                repeat ($urandom_range(gapmax, 1)) @(posedge tx_clk);
                #1;
            end
            src_valid[s] = 1'b1;
            src_data[s]  = 8'((base + b) & 255);
            src_last[s]  = (b == len - 1);
            t = 0;
            @(negedge tx_clk);
            while (!req_ready[s] && !abort && t < 5000) begin
                @(negedge tx_clk);
                t++;
            end
            if (abort) break;
            if (t >= 5000) begin
                check("ready_timeout", t, 0);
                break;
            end
            @(posedge tx_clk);
            #1;
            if (b < 1024) sb.push_back('{addr: 10'(b), data: src_data[s]});
            bytes_sent[s]++;
            if (b == len - 1) begin
                for (int p = len; p < 60; p++) sb.push_back('{addr: 10'(p), data: 8'h00});
            end
        end
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
    endtask

    task automatic finish_tx(input int exp_size, input int hold, input int exp_grant);
        int t;
        int gap;
        int te_hi;
        t = 0;
        while (!tx_enable && t < 5000) begin
            @(negedge tx_clk);
            t++;
        end
        check("tx_enable_seen", t < 5000, 1);
        if (t >= 5000) return;
        check("packet_size", packet_size, exp_size);
        check("grant_id", grant_id, exp_grant);
        repeat (3) @(negedge tx_clk);
        check("tx_enable_held", tx_enable, 1);
        check("packet_size_stable", packet_size, exp_size);
        @(posedge tx_clk);
        #1 tx_finished = 1'b1;
        @(negedge tx_clk);
        check("te_with_finished", tx_enable, 1);
        gap = 0;
        te_hi = 0;
        t = 0;
        while (t < 1000) begin
            @(negedge tx_clk);
            t++;
            if (t == hold) tx_finished = 1'b0;
            if (!busy) break;
            if (tx_enable) te_hi++;
            else gap++;
        end
        tx_finished = 1'b0;
        check("te_after_finished", te_hi, 0);
        check("ifg_cycles", gap, 192);
    endtask

    task automatic run_row(input row_t r);
        int r0;
        int t;
        r0 = rises;
        drive_frame(r.src, r.len, r.gapmax, r.src * 128);
        if (r.sent != 0) begin
            finish_tx(r.size, r.hold, r.src);
        end else begin
            t = 0;
            while (busy && t < 2000) begin
                @(negedge tx_clk);
                t++;
            end
            check("drop_idle", busy, 0);
            repeat (5) @(negedge tx_clk);
        end
        check("drop_count", drop_count, r.drops);
        check("tx_rises", rises - r0, r.sent);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int t;
        rows[0] = '{src: 0, len: 100,  gapmax: 0, hold: 1, sent: 1, size: 99,   drops: 0};
        rows[1] = '{src: 1, len: 10,   gapmax: 0, hold: 1, sent: 1, size: 59,   drops: 0};
        rows[2] = '{src: 0, len: 60,   gapmax: 0, hold: 2, sent: 1, size: 59,   drops: 0};
        rows[3] = '{src: 1, len: 59,   gapmax: 0, hold: 1, sent: 1, size: 59,   drops: 0};
        rows[4] = '{src: 0, len: 61,   gapmax: 0, hold: 1, sent: 1, size: 60,   drops: 0};
        rows[5] = '{src: 1, len: 1,    gapmax: 0, hold: 1, sent: 1, size: 59,   drops: 0};
        rows[6] = '{src: 0, len: 1025, gapmax: 0, hold: 1, sent: 0, size: 0,    drops: 1};
        rows[7] = '{src: 1, len: 1024, gapmax: 0, hold: 1, sent: 1, size: 1023, drops: 1};
        rows[8] = '{src: 0, len: 30,   gapmax: 5, hold: 3, sent: 1, size: 59,   drops: 1};
        rows[9] = '{src: 1, len: 80,   gapmax: 5, hold: 3, sent: 1, size: 79,   drops: 1};

        for (int s = 0; s < 2; s++) begin
            src_valid[s] = 1'b0;
            src_data[s]  = 8'h00;
            src_last[s]  = 1'b0;
            bytes_sent[s] = 0;
        end
        tx_finished = 1'b0;
        tx_rst = 1'b1;
        repeat (3) @(negedge tx_clk);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_buf_we", buf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_packet_size", packet_size, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_grant", grant_id, 0);
        tx_rst = 1'b0;
        repeat (2) @(negedge tx_clk);

        for (int i = 0; i < 10; i++) run_row(rows[i]);

        // Both sources continuously valid: grants must alternate.
        fork
            begin
                for (int k = 0; k < 3; k++) drive_frame(0, 20, 0, 16 * k);
            end
            begin
                for (int k = 0; k < 3; k++) drive_frame(1, 20, 0, 100 + 16 * k);
            end
            begin
                for (int k = 0; k < 6; k++) finish_tx(59, 1, k % 2);
            end
        join
        check("rr_sb_drained", sb.size(), 0);

        // Reset in the middle of loading a frame.
        bytes_sent[0] = 0;
        fork
            drive_frame(0, 100, 0, 7);
            begin
                t = 0;
                while (bytes_sent[0] < 40 && t < 2000) begin
                    @(negedge tx_clk);
                    t++;
                end
                check("reach_byte40", bytes_sent[0] >= 40, 1);
                @(negedge tx_clk);
                tx_rst = 1'b1;
                abort  = 1'b1;
                #1;
                check("mid_load_rst_buf_we", buf_we, 0);
                check("mid_load_rst_ready", req_ready, 0);
                check("mid_load_rst_busy", busy, 0);
                check("mid_load_rst_te", tx_enable, 0);
                repeat (3) @(negedge tx_clk);
                check("mid_load_rst_drops", drop_count, 0);
                check("mid_load_rst_size", packet_size, 0);
                sb.delete();
                tx_rst = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (2) @(negedge tx_clk);
        run_row('{src: 0, len: 20, gapmax: 2, hold: 1, sent: 1, size: 59, drops: 0});

        // Reset while the frame is being transmitted.
        drive_frame(1, 70, 0, 3);
        t = 0;
        while (!tx_enable && t < 2000) begin
            @(negedge tx_clk);
            t++;
        end
        check("send_reached", tx_enable, 1);
        @(negedge tx_clk);
        tx_rst = 1'b1;
        #1;
        check("mid_send_rst_te", tx_enable, 0);
        check("mid_send_rst_busy", busy, 0);
        check("mid_send_rst_buf_we", buf_we, 0);
        check("mid_send_rst_ready", req_ready, 0);
        repeat (2) @(negedge tx_clk);
        sb.delete();
        tx_rst = 1'b0;
        repeat (2) @(negedge tx_clk);
        run_row('{src: 1, len: 65, gapmax: 0, hold: 1, sent: 1, size: 64, drops: 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
